os_core: RTL and testbench
==========================

OS_CORE -- requirements
Module: os_core

Interface
REQ-001 Parameters: bw=4 (operand bits), psum_bw=16 (accumulator bits), row=8 (input channels), col=8 (output channels).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; clears all state immediately.
REQ-004 inst  in  41  instruction word: [40] max_pool_en, [39] psum_bypass, [38] acc, [37] CEN_pmem, [36] WEN_pmem, [35:27] A_pmem, [26] CEN1_xmem, [25:18] A1_xmem, [17] CEN0_xmem, [16] WEN0_xmem, [15:8] A0_xmem, [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] mode, [1] execute, [0] load.
REQ-005 D_xmem  in  bw*row=32  write data for xmem port 0.
REQ-006 ofifo_valid  out  1  every OFIFO column holds at least one entry.
REQ-007 sfp_out  out  col*psum_bw=128  registered SFP output; lane c in bits [16c+15:16c].
REQ-008 l0_ready  out  1  L0 not full.
REQ-009 ififo_ready  out  1  IFIFO not full.

Function
REQ-010 xmem: 256x32 synchronous SRAM; all enables active-low.
- Port 0: write D_xmem at A0 when CEN0=0 and WEN0=0; read A0 when CEN0=0 and WEN0=1.
- Port 1: read-only at A1 when CEN1=0.
- Read data Q0/Q1 valid the cycle after the access and held until the next read.
REQ-011 L0 (activations): when l0_wr=1, write Q0 as one 32-bit word.
REQ-012 IFIFO (weights): when ififo_wr=1, write Q1 as one 32-bit word.
REQ-013 L0 and IFIFO: depth 64 each; write to a full FIFO and read from an empty FIFO are ignored; simultaneous read and write on a non-empty FIFO both take effect.
REQ-014 Array: 8x8 PEs; PE(r,c) sums activation nibble r times weight nibble c.
- Activation nibble r enters row r from the west, delayed r cycles (skew).
- Weight nibble c enters column c from the north, delayed c cycles.
- Operands travel one PE per cycle: activations eastward, weights southward.
REQ-015 Arithmetic: activation unsigned 4-bit; weight signed 4-bit; product sign-extended to 16 bits; accumulation wraps modulo 2^16.
REQ-016 Execute (mode=1, execute=1):
- Pop one word from L0 (when l0_rd=1) and one from IFIFO (when ififo_rd=1).
- Every PE with a valid operand pair adds the product to its accumulator.
- Invalid operands (FIFO empty or bubble) contribute 0.
REQ-017 Load (mode=1, load=1, execute=0): each column shifts its accumulators one row south per cycle.
- Row 7's value is pushed into that column's OFIFO lane; row 0 is filled with 0.
- Row 7 result leaves first; 8 valid results per column, then zeros.
REQ-018 execute and load both 1: execute wins. mode=0: array holds its state.
REQ-019 OFIFO: 8 lanes x 16 bits, depth 16.
- Push on every load cycle; a push to a full lane is dropped.
- ofifo_rd=1 with ofifo_valid=1 pops one 128-bit word.
REQ-020 pmem: 512x128 synchronous SRAM, addressed by A_pmem.
- When CEN_pmem=0 and WEN_pmem=0, write the current OFIFO head word.
- When CEN_pmem=0 and WEN_pmem=1, read the word.
REQ-021 SFP updates only on cycles where the OFIFO is popped, otherwise holds. New value selection, in priority order:
- psum_bypass=1: raw popped word.
- acc=1: popped word plus the pmem read word, lane-wise, modulo 2^16.
- max_pool_en=1: lane-wise ReLU (negative → 0) of the popped word.
- otherwise: popped word unchanged.
REQ-022 Ready flags are combinational from FIFO occupancy; ofifo_valid is combinational.

Reset
REQ-023 While reset=0, and on its asynchronous assertion, all of the following clear:
- all FIFOs empty;
- PE accumulators and pipeline registers = 0;
- sfp_out = 0, ofifo_valid = 0;
- l0_ready = 1, ififo_ready = 1.
SRAM contents are not cleared.
REQ-024 Reset asserted mid-execute or mid-drain discards all in-flight data; operation resumes on the first rising edge after deassertion.

Verification
REQ-025 After reset → l0_ready=1, ififo_ready=1, ofifo_valid=0, sfp_out=0.
REQ-026 Streaming test:
- Stimulus: activations at xmem 0..26, weights at 128..154; 27 execute cycles, then 16 load cycles.
- Response: the 8 max-pool reads each match the golden 128-bit output, bottom row first.
REQ-027 All activations 0xF, all weights 0x1 (+1), 27 steps, drained → every sfp_out lane = 405 (0x0195).
REQ-028 All activations 0xF, all weights 0xF (-1), 27 steps, drained:
- max_pool_en=1 → every lane 0;
- psum_bypass=1 → every lane 0xFE6B.
REQ-029 Write 65 words to L0 without reading → l0_ready=0 after the 64th write; the 65th word is dropped.
REQ-030 Assert reset during a drain → ofifo_valid=0 immediately; a fresh run then produces the correct results.

Source files
------------

// File: rtl/os_core.sv
// os_core: 8x8 output-stationary systolic core with activation/weight staging.
//
// Data path: xmem (256x32) -> L0 (activations) / IFIFO (weights) -> skewed
// systolic array -> OFIFO (8 lanes x 16 bits) -> SFP output register. pmem
// (512x128) stores OFIFO words and supplies the accumulate operand for SFP.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-low; clears FIFOs, array, sfp_out
//   inst[40:0]   instruction word (field map in the decode block below)
//   D_xmem       write data for xmem port 0
//   ofifo_valid  OFIFO holds at least one word
//   sfp_out      registered SFP result, lane c in [16c+15:16c]
//   l0_ready     L0 not full
//   ififo_ready  IFIFO not full
//
// Handshake: every FIFO accepts a write only when it is not full (or is full
// but popped in the same cycle) and performs a read only when it is not empty;
// requests outside those conditions are silently ignored.

module os_fifo #(
  parameter int width = 32,
  parameter int depth = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int aw = $clog2(depth);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wptr, rptr;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  assign do_rd = rd && !empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_wr = wr && (!full || do_rd);
  assign head  = mem[rptr[aw-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (aw+1)'(1);
      if (do_rd) rptr <= rptr + (aw+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[aw-1:0]] <= wdata;
  end
endmodule

module os_core #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int row     = 8,
  parameter int col     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [40:0]              inst,
  input  logic [bw*row-1:0]        D_xmem,
  output logic                     ofifo_valid,
  output logic [col*psum_bw-1:0]   sfp_out,
  output logic                     l0_ready,
  output logic                     ififo_ready
);
  // Instruction decode
  logic max_pool_en, psum_bypass, acc_add, cen_pmem, wen_pmem;
  logic cen1_xmem, cen0_xmem, wen0_xmem;
  logic ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, mode, execute, load;
  logic [8:0] a_pmem;
  logic [7:0] a1_xmem, a0_xmem;

  assign max_pool_en = inst[40];
  assign psum_bypass = inst[39];
  assign acc_add     = inst[38];
  assign cen_pmem    = inst[37];
  assign wen_pmem    = inst[36];
  assign a_pmem      = inst[35:27];
  assign cen1_xmem   = inst[26];
  assign a1_xmem     = inst[25:18];
  assign cen0_xmem   = inst[17];
  assign wen0_xmem   = inst[16];
  assign a0_xmem     = inst[15:8];
  assign ofifo_rd    = inst[7];
  assign ififo_wr    = inst[6];
  assign ififo_rd    = inst[5];
  assign l0_rd       = inst[4];
  assign l0_wr       = inst[3];
  assign mode        = inst[2];
  assign execute     = inst[1];
  assign load        = inst[0];

  logic exec_cyc, load_cyc;
  assign exec_cyc = mode && execute;
  assign load_cyc = mode && load && !execute;   // execute has priority

  // xmem: port 0 read/write, port 1 read-only; read data held until next read
  logic [bw*row-1:0] xmem [256];
  logic [bw*row-1:0] q0, q1;

  always_ff @(posedge clk) begin
    if (!cen0_xmem && !wen0_xmem) xmem[a0_xmem] <= D_xmem;
    if (!cen0_xmem && wen0_xmem)  q0 <= xmem[a0_xmem];
    if (!cen1_xmem)               q1 <= xmem[a1_xmem];
  end

  // Operand staging FIFOs; pops happen only on execute cycles
  logic [bw*row-1:0] l0_head, if_head;
  logic l0_full, l0_empty, if_full, if_empty;
  logic act_pop, wt_pop;

  os_fifo #(.width(bw*row), .depth(64)) u_l0 (
    .clk(clk), .reset(reset), .wr(l0_wr), .wdata(q0), .rd(exec_cyc && l0_rd),
    .head(l0_head), .full(l0_full), .empty(l0_empty));

  os_fifo #(.width(bw*row), .depth(64)) u_ififo (
    .clk(clk), .reset(reset), .wr(ififo_wr), .wdata(q1), .rd(exec_cyc && ififo_rd),
    .head(if_head), .full(if_full), .empty(if_empty));

  assign act_pop     = exec_cyc && l0_rd && !l0_empty;
  assign wt_pop      = exec_cyc && ififo_rd && !if_empty;
  assign l0_ready    = !l0_full;
  assign ififo_ready = !if_full;

  // Skew: row r / column c operand is delayed r / c execute cycles. Each entry
  // carries {valid, nibble}; a missing pop injects a bubble.
  logic [bw:0] act_in [row];
  logic [bw:0] wt_in  [col];

  for (genvar r = 0; r < row; r++) begin : g_act_skew
    if (r == 0) begin : g_direct
      assign act_in[r] = {act_pop, l0_head[bw*r +: bw]};
    end else begin : g_delay
      logic [bw:0] dly [r];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < r; k++) dly[k] <= '0;
        end else if (exec_cyc) begin
          dly[0] <= {act_pop, l0_head[bw*r +: bw]};
          for (int k = 1; k < r; k++) dly[k] <= dly[k-1];
        end
      end
      assign act_in[r] = dly[r-1];
    end
  end

  for (genvar c = 0; c < col; c++) begin : g_wt_skew
    if (c == 0) begin : g_direct
      assign wt_in[c] = {wt_pop, if_head[bw*c +: bw]};
    end else begin : g_delay
      logic [bw:0] dly [c];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < c; k++) dly[k] <= '0;
        end else if (exec_cyc) begin
          dly[0] <= {wt_pop, if_head[bw*c +: bw]};
          for (int k = 1; k < c; k++) dly[k] <= dly[k-1];
        end
      end
      assign wt_in[c] = dly[c-1];
    end
  end

  // Unsigned activation times signed weight, wrapped to psum_bw bits.
  function automatic logic [psum_bw-1:0] mac_prod(input logic [bw-1:0] a,
                                                  input logic [bw-1:0] w);
    logic signed [psum_bw-1:0] as, ws;
    as = {{(psum_bw-bw){1'b0}}, a};
    ws = {{(psum_bw-bw){w[bw-1]}}, w};
    return as * ws;
  endfunction

  // PE grid: operands move east/south one PE per execute cycle; on load
  // cycles accumulators shift one row south with zero entering row 0.
  logic [bw:0]        a_out [row][col];
  logic [bw:0]        w_out [row][col];
  logic [psum_bw-1:0] p_out [row][col];

  for (genvar r = 0; r < row; r++) begin : g_row
    for (genvar c = 0; c < col; c++) begin : g_pe
      logic [bw:0]        a_west, w_north, a_q, w_q;
      logic [psum_bw-1:0] p_north, p_q;

      if (c == 0) begin : g_aw
        assign a_west = act_in[r];
      end else begin : g_ai
        assign a_west = a_out[r][c-1];
      end
      if (r == 0) begin : g_wn
        assign w_north = wt_in[c];
        assign p_north = '0;
      end else begin : g_wi
        assign w_north = w_out[r-1][c];
        assign p_north = p_out[r-1][c];
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          a_q <= '0;
          w_q <= '0;
          p_q <= '0;
        end else if (exec_cyc) begin
          a_q <= a_west;
          w_q <= w_north;
          if (a_q[bw] && w_q[bw]) p_q <= p_q + mac_prod(a_q[bw-1:0], w_q[bw-1:0]);
        end else if (load_cyc) begin
          p_q <= p_north;
        end
      end

      assign a_out[r][c] = a_q;
      assign w_out[r][c] = w_q;
      assign p_out[r][c] = p_q;
    end
  end

  // OFIFO: bottom row is pushed on every load cycle
  logic [col*psum_bw-1:0] ofifo_din, ofifo_head;
  logic ofifo_empty, ofifo_full_unused;

  always_comb begin
    ofifo_din = '0;
    for (int c = 0; c < col; c++) ofifo_din[psum_bw*c +: psum_bw] = p_out[row-1][c];
  end

  os_fifo #(.width(col*psum_bw), .depth(16)) u_ofifo (
    .clk(clk), .reset(reset), .wr(load_cyc), .wdata(ofifo_din), .rd(ofifo_rd),
    .head(ofifo_head), .full(ofifo_full_unused), .empty(ofifo_empty));

  assign ofifo_valid = !ofifo_empty;

  // pmem: writes capture the current OFIFO head word
  logic [col*psum_bw-1:0] pmem [512];
  logic [col*psum_bw-1:0] pmem_q;

  always_ff @(posedge clk) begin
    if (!cen_pmem && !wen_pmem) pmem[a_pmem] <= ofifo_head;
    if (!cen_pmem && wen_pmem)  pmem_q <= pmem[a_pmem];
  end

  // SFP: bypass > accumulate > ReLU > pass-through; updates only on pop
  logic [col*psum_bw-1:0] sfp_next;

  always_comb begin
    sfp_next = ofifo_head;
    if (!psum_bypass) begin
      if (acc_add) begin
        for (int c = 0; c < col; c++)
          sfp_next[psum_bw*c +: psum_bw] = ofifo_head[psum_bw*c +: psum_bw] +
                                           pmem_q[psum_bw*c +: psum_bw];
      end else if (max_pool_en) begin
        for (int c = 0; c < col; c++)
          if (ofifo_head[psum_bw*c + psum_bw-1]) sfp_next[psum_bw*c +: psum_bw] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        sfp_out <= '0;
    else if (ofifo_rd && ofifo_valid)  sfp_out <= sfp_next;
  end
endmodule

// File: tb/tb_os_core.sv
// tb_os_core: randomized scoreboard bench for os_core. Stimulus tasks push the
// expected SFP word when they issue an OFIFO pop; a negedge monitor compares
// sfp_out one cycle after each pop and checks that it holds otherwise.

module tb_os_core;
  localparam int B_MAXP = 40, B_BYP = 39, B_ACC = 38, B_CENP = 37, B_WENP = 36;
  localparam int B_CEN1 = 26, B_CEN0 = 17, B_WEN0 = 16, B_ORD = 7, B_IWR = 6;
  localparam int B_IRD = 5, B_L0RD = 4, B_L0WR = 3, B_MODE = 2, B_EXE = 1, B_LOAD = 0;

  // Clock / reset
  logic         clk = 1'b0;
  logic         reset;
  logic [40:0]  inst;
  logic [31:0]  d_xmem;
  logic         ofifo_valid, l0_ready, ififo_ready;
  logic [127:0] sfp_out;

  always #5 clk = ~clk;

  os_core dut (
    .clk(clk), .reset(reset), .inst(inst), .D_xmem(d_xmem),
    .ofifo_valid(ofifo_valid), .sfp_out(sfp_out),
    .l0_ready(l0_ready), .ififo_ready(ififo_ready));

  // Scoreboard state
  int           n_chk = 0, n_fail = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  act_w[70], wt_w[70];
  logic [127:0] raw_w[16], pm_model[16];
  logic         pend = 1'b0;
  logic [127:0] last_exp = '0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: a pop seen at one negedge is checked at the next one
  always @(negedge clk) begin
    if (!reset) begin
      pend     = 1'b0;
      last_exp = '0;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sfp_unexpected_pop: got %h expected no pop", sfp_out);
        end else begin
          last_exp = exp_q.pop_front();
          chk("sfp_pop", sfp_out, last_exp);
        end
      end else begin
        chk("sfp_hold", sfp_out, last_exp);
      end
      pend = inst[B_ORD] && ofifo_valid;
    end
  end

  // Reference model: every PE(r,c) sums act[r]*signed(wt[c]) over popped
  // words; drain order is bottom row first, then eight zero words.
  task automatic build_model(input int n);
    int pops, s;
    logic [3:0] a;
    logic signed [3:0] ws;
    pops = (n > 64) ? 64 : n;
    for (int k = 0; k < 16; k++) raw_w[k] = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        s = 0;
        for (int i = 0; i < pops; i++) begin
          a  = act_w[i][4*r +: 4];
          ws = wt_w[i][4*c +: 4];
          s  = s + int'(a) * int'(ws);
        end
        raw_w[7-r][16*c +: 16] = s[15:0];
      end
  endtask

  // m: 0 plain, 1 ReLU, 2 bypass (ReLU bit also set), 3 accumulate (ReLU bit also set)
  function automatic logic [127:0] sfp_model(input logic [127:0] raw, input int m,
                                             input logic [127:0] pm);
    logic [127:0] o;
    logic [15:0]  lane;
    o = '0;
    for (int c = 0; c < 8; c++) begin
      lane = raw[16*c +: 16];
      if (m == 1 && lane[15])  lane = 16'd0;
      else if (m == 3)         lane = lane + pm[16*c +: 16];
      o[16*c +: 16] = lane;
    end
    return o;
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge
  function automatic logic [40:0] idle_inst();
    logic [40:0] w;
    w = '0;
    w[B_CENP] = 1'b1; w[B_WENP] = 1'b1; w[B_CEN1] = 1'b1;
    w[B_CEN0] = 1'b1; w[B_WEN0] = 1'b1;
    return w;
  endfunction

  task automatic step(input logic [40:0] w);
    inst = w;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    logic [40:0] w;
    int wr_cnt;
    for (int i = 0; i < n; i++) begin
      w = idle_inst(); w[B_CEN0] = 1'b0; w[B_WEN0] = 1'b0; w[15:8] = 8'(i);
      d_xmem = act_w[i];
      step(w);
    end
    for (int i = 0; i < n; i++) begin
      w = idle_inst(); w[B_CEN0] = 1'b0; w[B_WEN0] = 1'b0; w[15:8] = 8'(128 + i);
      d_xmem = wt_w[i];
      step(w);
    end
    wr_cnt = 0;
    for (int k = 0; k <= n; k++) begin
      w = idle_inst();
      if (k < n) begin
        w[B_CEN0] = 1'b0; w[15:8] = 8'(k);
        w[B_CEN1] = 1'b0; w[25:18] = 8'(128 + k);
      end
      if (k > 0) begin
        w[B_L0WR] = 1'b1; w[B_IWR] = 1'b1;
      end
      step(w);
      if (k > 0) begin
        wr_cnt++;
        chk("l0_ready_fill", l0_ready, (wr_cnt < 64));
        chk("ififo_ready_fill", ififo_ready, (wr_cnt < 64));
      end
    end
  endtask

  task automatic exec_phase(input int n);
    logic [40:0] w;
    int pops;
    pops = (n > 64) ? 64 : n;
    for (int s = 0; s < pops + 16; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        // mode=0: array must hold even with execute/load raised
        w = idle_inst(); w[B_EXE] = 1'b1; w[B_LOAD] = 1'b1;
        step(w);
      end
      w = idle_inst(); w[B_MODE] = 1'b1; w[B_EXE] = 1'b1;
      w[B_LOAD] = 1'($urandom_range(0, 1));
      w[B_L0RD] = 1'b1; w[B_IRD] = 1'b1;
      step(w);
    end
  endtask

  task automatic load_phase(input int cnt);
    logic [40:0] w;
    for (int s = 0; s < cnt; s++) begin
      w = idle_inst(); w[B_MODE] = 1'b1; w[B_LOAD] = 1'b1;
      step(w);
    end
  endtask

  task automatic drain(input string tag, input int m);
    logic [40:0] w;
    for (int k = 0; k < 16; k++) begin
      if (m == 3) begin
        w = idle_inst(); w[B_CENP] = 1'b0; w[B_WENP] = 1'b1; w[35:27] = 9'(k);
        step(w);
      end
      w = idle_inst(); w[B_ORD] = 1'b1;
      case (m)
        1: w[B_MAXP] = 1'b1;
        2: begin w[B_BYP] = 1'b1; w[B_MAXP] = 1'b1; end
        3: begin w[B_ACC] = 1'b1; w[B_MAXP] = 1'b1; end
        default: ;
      endcase
      if (m != 3) begin
        w[B_CENP] = 1'b0; w[B_WENP] = 1'b0; w[35:27] = 9'(k);
      end
      exp_q.push_back(sfp_model(raw_w[k], m, pm_model[k]));
      if (m != 3) pm_model[k] = raw_w[k];
      step(w);
    end
    chk({tag, "_ofifo_empty"}, ofifo_valid, 1'b0);
  endtask

  // pat: 0 random, 1 act 0xF / wt +1, 2 act 0xF / wt -1
  task automatic set_data(input int n, input int pat);
    for (int i = 0; i < n; i++) begin
      act_w[i] = (pat == 0) ? $urandom : 32'hFFFF_FFFF;
      case (pat)
        1:       wt_w[i] = 32'h1111_1111;
        2:       wt_w[i] = 32'hFFFF_FFFF;
        default: wt_w[i] = $urandom;
      endcase
    end
  endtask

  task automatic run_case(input string tag, input int n, input int m, input int pat);
    set_data(n, pat);
    fill(n);
    exec_phase(n);
    load_phase(16);
    chk({tag, "_ofifo_valid"}, ofifo_valid, 1'b1);
    build_model(n);
    drain(tag, m);
    step(idle_inst());
    step(idle_inst());
  endtask

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Test sequence
  initial begin
    reset  = 1'b0;
    inst   = idle_inst();
    d_xmem = '0;
    for (int k = 0; k < 16; k++) pm_model[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_l0_ready", l0_ready, 1'b1);
    chk("rst_ififo_ready", ififo_ready, 1'b1);
    chk("rst_ofifo_valid", ofifo_valid, 1'b0);
    chk("rst_sfp_out", sfp_out, '0);

    run_case("ones", 27, 0, 1);
    run_case("neg_relu", 27, 1, 2);
    run_case("neg_bypass", 27, 2, 2);
    run_case("rand_pool", 27, 1, 0);
    run_case("rand_acc", 27, 3, 0);
    run_case("l0_full", 65, 0, 0);

    // Reset in the middle of a drain
    set_data(20, 0);
    fill(20);
    exec_phase(20);
    load_phase(5);
    chk("mid_ofifo_valid", ofifo_valid, 1'b1);
    inst  = idle_inst();
    reset = 1'b0;
    #1;
    chk("mid_rst_ofifo_valid", ofifo_valid, 1'b0);
    chk("mid_rst_sfp_out", sfp_out, '0);
    chk("mid_rst_l0_ready", l0_ready, 1'b1);
    chk("mid_rst_ififo_ready", ififo_ready, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_case("after_reset", 27, 2, 0);
    run_case("rand_short", 9, 0, 0);

    chk("scoreboard_drained", 128'(exp_q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
